// File: rtl/gray_decoder.sv
// Gray-code count receiver: decodes each sample to binary, checks that it is
// the successor of the previous one, and tracks lock, wrap and error status.
module gray_decoder #(
    parameter int CBITS  = 11,
    parameter int ECBITS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CBITS-1:0]  gray_in,
    input  logic              gray_vld,
    output logic [CBITS-1:0]  bin_out,
    output logic              bin_vld,
    output logic              locked,
    output logic              err,
    output logic              wrap,
    output logic [ECBITS-1:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_t;

    state_t           state;
    logic [CBITS-1:0] ref_q;
    logic [CBITS-1:0] bin;
    logic             succ;

    // Prefix XOR from the MSB down
    always_comb begin
        bin = '0;
        bin[CBITS-1] = gray_in[CBITS-1];
        for (int i = CBITS - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray_in[i];
        end
    end

    assign succ   = (bin == ref_q + CBITS'(1));
    assign locked = (state == LOCK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ref_q   <= '0;
            bin_out <= '0;
            bin_vld <= 1'b0;
            err     <= 1'b0;
            wrap    <= 1'b0;
            err_cnt <= '0;
        end else begin
            bin_vld <= 1'b0;
            err     <= 1'b0;
            wrap    <= 1'b0;
            if (gray_vld) begin
                bin_out <= bin;
                bin_vld <= 1'b1;
                ref_q   <= bin;
                unique case (state)
                    IDLE: state <= ACQ;
                    ACQ: begin
                        if (succ) state <= LOCK;
                    end
                    LOCK: begin
                        if (succ) begin
                            wrap <= (bin == '0);
                        end else begin
                            err   <= 1'b1;
                            state <= ACQ;
                            if (err_cnt != '1) err_cnt <= err_cnt + ECBITS'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
